tl_memory_access: RTL and testbench

MEM stage of the 5-stage MIPS pipeline, together with the MEM/WB pipeline register. It performs byte, halfword and word loads and stores on an internal data memory. It sign- or zero-extends load data. It registers the read data, the ALU result, the WB control bits and the destination register for the write-back stage.

---
 rtl/tl_memory_access.sv | 138 +++++++++++++
 tb/tb_tl_memory_access.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tl_memory_access.sv
// MEM stage of the 5-stage MIPS pipeline plus the MEM/WB register: byte/half/word loads and stores.
// Optional debug read port enabled by defining MEM_DEBUG_PORT_EN.
module tl_memory_access #(
  parameter int LEN                  = 32,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_CTRL_MEM          = 5,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_ADDR_MEM          = 10
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [LEN-1:0]                  i_result_alu,
  input  logic [LEN-1:0]                  i_write_data_mem,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  input  logic                            i_stall,
  input  logic                            i_flush,
`ifdef MEM_DEBUG_PORT_EN
  input  logic [NB_ADDR_MEM-1:0]          i_debug_addr,
  output logic [LEN-1:0]                  o_debug_data,
`endif
  output logic [LEN-1:0]                  o_read_data,
  output logic [LEN-1:0]                  o_result_alu,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic                            o_misaligned
);

  localparam int NBYTE = LEN / 8;

  logic [LEN-1:0] mem_q [1<<NB_ADDR_MEM];

  logic                   mem_rd, mem_wr, ld_uns;
  logic [1:0]             size, lane;
  logic [NB_ADDR_MEM-1:0] idx;
  logic [LEN-1:0]         word, ld_val, wd;
  logic [NBYTE-1:0]       be;
  logic [7:0]             byte_v;
  logic [15:0]            half_v;
  logic                   misal, we, unused_addr;

  logic [LEN-1:0]                  rd_d, rd_q, alu_q;
  logic [NB_CTRL_WB-1:0]           wb_q;
  logic [NB_ADDRESS_REGISTROS-1:0] wreg_q;
  logic                            mis_d, mis_q;

  assign mem_rd      = i_ctrl_mem[4];
  assign mem_wr      = i_ctrl_mem[3];
  assign size        = i_ctrl_mem[2:1];
  assign ld_uns      = i_ctrl_mem[0];
  assign lane        = i_result_alu[1:0];
  assign idx         = i_result_alu[NB_ADDR_MEM+1:2];
  assign unused_addr = ^i_result_alu[LEN-1:NB_ADDR_MEM+2];

  assign word   = mem_q[idx];
  assign byte_v = word[8*lane +: 8];
  assign half_v = word[16*lane[1] +: 16];

  // Size code 10 is decoded as a word access everywhere.
  always_comb begin
    misal = 1'b0;
    case (size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = lane[0];
      default: misal = (lane != 2'b00);
    endcase
  end

  always_comb begin
    ld_val = '0;
    case (size)
      2'b00:   ld_val = ld_uns ? {{(LEN-8){1'b0}}, byte_v} : {{(LEN-8){byte_v[7]}}, byte_v};
      2'b01:   ld_val = ld_uns ? {{(LEN-16){1'b0}}, half_v} : {{(LEN-16){half_v[15]}}, half_v};
      default: ld_val = word;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the target lane.
  always_comb begin
    be = '0;
    wd = i_write_data_mem;
    case (size)
      2'b00: begin
        be[lane] = 1'b1;
        wd       = {NBYTE{i_write_data_mem[7:0]}};
      end
      2'b01: begin
        be[2*lane[1] +: 2] = 2'b11;
        wd                 = {(NBYTE/2){i_write_data_mem[15:0]}};
      end
      default: be = '1;
    endcase
  end

  assign we    = mem_wr && !misal && !i_stall && !i_flush && !i_reset;
  assign rd_d  = (mem_rd && !mem_wr && !misal) ? ld_val : '0;
  assign mis_d = mis_q | ((mem_rd | mem_wr) & misal);

  always_ff @(posedge i_clk) begin
    if (we) begin
      for (int b = 0; b < NBYTE; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_q   <= '0;
      alu_q  <= '0;
      wb_q   <= '0;
      wreg_q <= '0;
      mis_q  <= 1'b0;
    end else if (i_flush) begin
      rd_q   <= '0;
      alu_q  <= '0;
      wb_q   <= '0;
      wreg_q <= '0;
    end else if (!i_stall) begin
      rd_q   <= rd_d;
      alu_q  <= i_result_alu;
      wb_q   <= i_ctrl_wb;
      wreg_q <= i_write_reg;
      mis_q  <= mis_d;
    end
  end

  assign o_read_data  = rd_q;
  assign o_result_alu = alu_q;
  assign o_ctrl_wb    = wb_q;
  assign o_write_reg  = wreg_q;
  assign o_misaligned = mis_q;

`ifdef MEM_DEBUG_PORT_EN
  assign o_debug_data = mem_q[i_debug_addr];
`endif

endmodule

// File: tb/tb_tl_memory_access.sv
// Scoreboard bench for tl_memory_access: expected MEM/WB outputs are queued as each cycle is driven.
module tb_tl_memory_access;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] alu, wdat;
  logic [4:0]  ctrl, wreg;
  logic [1:0]  wb;
  logic [31:0] o_rd, o_alu;
  logic [1:0]  o_wb;
  logic [4:0]  o_wreg;
  logic        o_mis;

  always #5 clk = ~clk;

  tl_memory_access dut (
    .i_clk(clk), .i_reset(rst), .i_result_alu(alu), .i_write_data_mem(wdat),
    .i_ctrl_mem(ctrl), .i_ctrl_wb(wb), .i_write_reg(wreg), .i_stall(stall), .i_flush(flush),
    .o_read_data(o_rd), .o_result_alu(o_alu), .o_ctrl_wb(o_wb), .o_write_reg(o_wreg),
    .o_misaligned(o_mis)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [1:0]  wb;
    logic [4:0]  wr;
    logic        mis;
  } out_t;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [1:0]  wb;
    logic [4:0]  wreg;
    logic        stall, flush, rst;
    out_t        exp;
  } row_t;

  // ctrl = {MemRead, MemWrite, size[1:0], unsigned}
  localparam logic [4:0] LW = 5'b10110, SW = 5'b01110, SB = 5'b01000, SH = 5'b01010,
                         LB = 5'b10000, LBU = 5'b10001, LH = 5'b10010, LHU = 5'b10011,
                         RW = 5'b11110, LW10 = 5'b10100;

  out_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic out_t o(logic [31:0] rd, logic [31:0] a, logic [1:0] w, logic [4:0] r, logic m);
    return '{rd: rd, alu: a, wb: w, wr: r, mis: m};
  endfunction

  function automatic row_t mk(logic [4:0] c, logic [31:0] a, logic [31:0] d, logic [1:0] w,
                              logic [4:0] r, logic s, logic f, logic x, out_t e);
    return '{ctrl: c, addr: a, wdat: d, wb: w, wreg: r, stall: s, flush: f, rst: x, exp: e};
  endfunction

  task automatic cyc(input row_t r, output out_t got);
    ctrl = r.ctrl; alu = r.addr; wdat = r.wdat; wb = r.wb; wreg = r.wreg;
    stall = r.stall; flush = r.flush; rst = r.rst;
    sb.push_back(r.exp);
    @(posedge clk);
    #1;
    got = '{rd: o_rd, alu: o_alu, wb: o_wb, wr: o_wreg, mis: o_mis};
  endtask

  task automatic test_reset;
    row_t r[2]; out_t got, e;
    r[0] = mk(LW, 32'h10, 0, 2'b11, 5'd3, 0, 0, 1, o(0, 0, 0, 0, 0));
    r[1] = mk(SW, 32'h10, 32'hFFFF_FFFF, 2'b11, 5'd3, 0, 0, 1, o(0, 0, 0, 0, 0));
    foreach (r[i]) begin
      cyc(r[i], got); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_word;
    row_t r[2]; out_t got, e;
    r[0] = mk(SW, 32'h10, 32'hDEAD_BEEF, 2'b00, 5'd0, 0, 0, 0, o(0, 32'h10, 0, 0, 0));
    r[1] = mk(LW, 32'h10, 0, 2'b11, 5'd7, 0, 0, 0, o(32'hDEAD_BEEF, 32'h10, 2'b11, 5'd7, 0));
    foreach (r[i]) begin
      cyc(r[i], got); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL word[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_byte_half;
    row_t r[7]; out_t got, e;
    r[0] = mk(SB,  32'h13, 32'h1234_5680, 2'b00, 5'd0, 0, 0, 0, o(0, 32'h13, 0, 0, 0));
    r[1] = mk(LB,  32'h13, 0, 2'b11, 5'd8, 0, 0, 0, o(32'hFFFF_FF80, 32'h13, 2'b11, 5'd8, 0));
    r[2] = mk(LBU, 32'h13, 0, 2'b11, 5'd8, 0, 0, 0, o(32'h0000_0080, 32'h13, 2'b11, 5'd8, 0));
    r[3] = mk(LW,  32'h10, 0, 2'b11, 5'd8, 0, 0, 0, o(32'h80AD_BEEF, 32'h10, 2'b11, 5'd8, 0));
    r[4] = mk(LH,  32'h12, 0, 2'b10, 5'd9, 0, 0, 0, o(32'hFFFF_80AD, 32'h12, 2'b10, 5'd9, 0));
    r[5] = mk(LHU, 32'h10, 0, 2'b10, 5'd9, 0, 0, 0, o(32'h0000_BEEF, 32'h10, 2'b10, 5'd9, 0));
    // 0x1010 aliases word 4 in a 1024-word memory
    r[6] = mk(LW, 32'h1010, 0, 2'b11, 5'd1, 0, 0, 0, o(32'h80AD_BEEF, 32'h1010, 2'b11, 5'd1, 0));
    foreach (r[i]) begin
      cyc(r[i], got); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL byte_half[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_misaligned;
    row_t r[5]; out_t got, e;
    r[0] = mk(SW, 32'h20, 32'hCAFE_F00D, 2'b00, 5'd0, 0, 0, 0, o(0, 32'h20, 0, 0, 0));
    r[1] = mk(SH, 32'h21, 32'h0000_1234, 2'b00, 5'd0, 0, 0, 0, o(0, 32'h21, 0, 0, 1));
    r[2] = mk(LW, 32'h20, 0, 2'b11, 5'd2, 0, 0, 0, o(32'hCAFE_F00D, 32'h20, 2'b11, 5'd2, 1));
    r[3] = mk(LW, 32'h22, 0, 2'b11, 5'd2, 0, 0, 0, o(0, 32'h22, 2'b11, 5'd2, 1));
    r[4] = mk(LB, 32'h23, 0, 2'b11, 5'd2, 0, 0, 0, o(32'hFFFF_FFCA, 32'h23, 2'b11, 5'd2, 1));
    foreach (r[i]) begin
      cyc(r[i], got); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL misaligned[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_stall;
    row_t r[7]; out_t got, e;
    r[0] = mk(SW, 32'h30, 32'h1111_1111, 2'b00, 5'd0, 0, 0, 0, o(0, 32'h30, 0, 0, 1));
    r[1] = mk(LW, 32'h10, 0, 2'b11, 5'd9, 0, 0, 0, o(32'h80AD_BEEF, 32'h10, 2'b11, 5'd9, 1));
    r[2] = mk(SW, 32'h30, 32'h55, 2'b00, 5'd0, 1, 0, 0, o(32'h80AD_BEEF, 32'h10, 2'b11, 5'd9, 1));
    r[3] = mk(SW, 32'h30, 32'h55, 2'b00, 5'd0, 1, 0, 0, o(32'h80AD_BEEF, 32'h10, 2'b11, 5'd9, 1));
    r[4] = mk(LW, 32'h30, 0, 2'b11, 5'd10, 0, 0, 0, o(32'h1111_1111, 32'h30, 2'b11, 5'd10, 1));
    r[5] = mk(SW, 32'h30, 32'h55, 2'b00, 5'd0, 0, 0, 0, o(0, 32'h30, 0, 0, 1));
    r[6] = mk(LW, 32'h30, 0, 2'b11, 5'd10, 0, 0, 0, o(32'h55, 32'h30, 2'b11, 5'd10, 1));
    foreach (r[i]) begin
      cyc(r[i], got); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL stall[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_flush;
    row_t r[3]; out_t got, e;
    r[0] = mk(SW, 32'h30, 32'h99, 2'b11, 5'd4, 1, 1, 0, o(0, 0, 0, 0, 1));
    r[1] = mk(LW, 32'h30, 0, 2'b11, 5'd11, 0, 0, 0, o(32'h55, 32'h30, 2'b11, 5'd11, 1));
    r[2] = mk(LW, 32'h30, 0, 2'b11, 5'd11, 0, 1, 0, o(0, 0, 0, 0, 1));
    foreach (r[i]) begin
      cyc(r[i], got); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL flush[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_rw_size;
    row_t r[3]; out_t got, e;
    r[0] = mk(RW,   32'h40, 32'h77, 2'b11, 5'd4, 0, 0, 0, o(0, 32'h40, 2'b11, 5'd4, 1));
    r[1] = mk(LW,   32'h40, 0, 2'b11, 5'd5, 0, 0, 0, o(32'h77, 32'h40, 2'b11, 5'd5, 1));
    r[2] = mk(LW10, 32'h40, 0, 2'b01, 5'd6, 0, 0, 0, o(32'h77, 32'h40, 2'b01, 5'd6, 1));
    foreach (r[i]) begin
      cyc(r[i], got); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL rw_size[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_reset_midop;
    row_t r[2]; out_t got, e;
    r[0] = mk(SW, 32'h30, 32'hAA, 2'b11, 5'd3, 0, 0, 1, o(0, 0, 0, 0, 0));
    r[1] = mk(LW, 32'h30, 0, 2'b11, 5'd12, 0, 0, 0, o(32'h55, 32'h30, 2'b11, 5'd12, 0));
    foreach (r[i]) begin
      cyc(r[i], got); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_midop[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    alu = '0; wdat = '0; ctrl = '0; wreg = '0; wb = '0;
    test_reset;
    test_word;
    test_byte_half;
    test_misaligned;
    test_stall;
    test_flush;
    test_rw_size;
    test_reset_midop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
